// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI-Lite round-robin arbiter.
// Holds the per-path FSM state encodings and the AXI-Lite response codes.
package axil_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit searching upward from last+1 with wrap.
module rr_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned IDXW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;

    // Scan from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        idx  = '0;
        any  = |req;
        sum  = '0;
        cand = '0;
        for (int i = int'(N); i > 0; i--) begin
            sum  = {1'b0, last} + (IDXW+1)'(i);
            cand = (sum >= (IDXW+1)'(N)) ? IDXW'(sum - (IDXW+1)'(N)) : IDXW'(sum);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// N-to-1 AXI-Lite arbiter with independent round-robin write and read paths.
// One transaction in flight per path; the owning index doubles as the downstream ID.
module axil_rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter  int unsigned N          = 2,
    parameter  int unsigned AW         = 32,
    parameter  int unsigned DW         = 32,
    parameter  int unsigned STRB_WIDTH = DW / 8,
    localparam int unsigned IDXW       = (N > 2) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [N*AW-1:0]         s_axil_awaddr,
    input  logic [N*3-1:0]          s_axil_awprot,
    input  logic [N-1:0]            s_axil_awvalid,
    output logic [N-1:0]            s_axil_awready,
    input  logic [N*DW-1:0]         s_axil_wdata,
    input  logic [N*STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic [N-1:0]            s_axil_wvalid,
    output logic [N-1:0]            s_axil_wready,
    output logic [N*2-1:0]          s_axil_bresp,
    output logic [N-1:0]            s_axil_bvalid,
    input  logic [N-1:0]            s_axil_bready,
    input  logic [N*AW-1:0]         s_axil_araddr,
    input  logic [N*3-1:0]          s_axil_arprot,
    input  logic [N-1:0]            s_axil_arvalid,
    output logic [N-1:0]            s_axil_arready,
    output logic [N*DW-1:0]         s_axil_rdata,
    output logic [N*2-1:0]          s_axil_rresp,
    output logic [N-1:0]            s_axil_rvalid,
    input  logic [N-1:0]            s_axil_rready,

    output logic [AW-1:0]           m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DW-1:0]           m_axil_wdata,
    output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [AW-1:0]           m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DW-1:0]           m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,

    output logic [IDXW-1:0]         wr_grant,
    output logic [IDXW-1:0]         rd_grant
);

    wr_state_e       wr_state;
    rd_state_e       rd_state;
    logic [IDXW-1:0] last_wr;
    logic [IDXW-1:0] last_rd;
    logic            aw_done;
    logic            w_done;
    logic [IDXW-1:0] wr_pick;
    logic [IDXW-1:0] rd_pick;
    logic            wr_any;
    logic            rd_any;
    logic            aw_hs;
    logic            w_hs;

    rr_pick #(.N(N), .IDXW(IDXW)) u_wr_pick (
        .req  (s_axil_awvalid),
        .last (last_wr),
        .idx  (wr_pick),
        .any  (wr_any)
    );

    rr_pick #(.N(N), .IDXW(IDXW)) u_rd_pick (
        .req  (s_axil_arvalid),
        .last (last_rd),
        .idx  (rd_pick),
        .any  (rd_any)
    );

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid & m_axil_wready;

    // Write path: only the granted requester is connected; everyone else sees zeros.
    always_comb begin
        m_axil_awaddr  = '0;
        m_axil_awprot  = '0;
        m_axil_awvalid = 1'b0;
        m_axil_wdata   = '0;
        m_axil_wstrb   = '0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        s_axil_awready = '0;
        s_axil_wready  = '0;
        s_axil_bvalid  = '0;
        s_axil_bresp   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if ((IDXW'(i) == wr_grant) && (wr_state != W_IDLE)) begin
                m_axil_awaddr = s_axil_awaddr[i*AW +: AW];
                m_axil_awprot = s_axil_awprot[i*3 +: 3];
                m_axil_wdata  = s_axil_wdata[i*DW +: DW];
                m_axil_wstrb  = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
                if (wr_state == W_ADDR) begin
                    m_axil_awvalid    = s_axil_awvalid[i] & ~aw_done;
                    s_axil_awready[i] = m_axil_awready & ~aw_done;
                    m_axil_wvalid     = s_axil_wvalid[i] & ~w_done;
                    s_axil_wready[i]  = m_axil_wready & ~w_done;
                end
                if (wr_state == W_RESP) begin
                    m_axil_bready        = s_axil_bready[i];
                    s_axil_bvalid[i]     = m_axil_bvalid;
                    s_axil_bresp[i*2 +: 2] = m_axil_bresp;
                end
            end
        end
    end

    // Read path mux, same scheme as the write path.
    always_comb begin
        m_axil_araddr  = '0;
        m_axil_arprot  = '0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        s_axil_rdata   = '0;
        s_axil_rresp   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if ((IDXW'(i) == rd_grant) && (rd_state != R_IDLE)) begin
                m_axil_araddr = s_axil_araddr[i*AW +: AW];
                m_axil_arprot = s_axil_arprot[i*3 +: 3];
                if (rd_state == R_ADDR) begin
                    m_axil_arvalid    = s_axil_arvalid[i];
                    s_axil_arready[i] = m_axil_arready;
                end
                if (rd_state == R_DATA) begin
                    m_axil_rready          = s_axil_rready[i];
                    s_axil_rvalid[i]       = m_axil_rvalid;
                    s_axil_rdata[i*DW +: DW] = m_axil_rdata;
                    s_axil_rresp[i*2 +: 2]   = m_axil_rresp;
                end
            end
        end
    end

    // AW and W may land in either order; the done flags remember which already fired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state <= W_IDLE;
            wr_grant <= '0;
            last_wr  <= IDXW'(N - 1);
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wr_any) begin
                        wr_grant <= wr_pick;
                        wr_state <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        wr_state <= W_RESP;
                    end else begin
                        aw_done <= aw_done | aw_hs;
                        w_done  <= w_done | w_hs;
                    end
                end
                W_RESP: begin
                    if (m_axil_bvalid && m_axil_bready) begin
                        last_wr  <= wr_grant;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_grant <= '0;
            last_rd  <= IDXW'(N - 1);
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (rd_any) begin
                        rd_grant <= rd_pick;
                        rd_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m_axil_arvalid && m_axil_arready) begin
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (m_axil_rvalid && m_axil_rready) begin
                        last_rd  <= rd_grant;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Scoreboard bench for axil_rr_arbiter: requester BFMs push expectations,
// a negedge monitor pops and compares on every handshake it observes.
module tb_axil_rr_arbiter;
    import axil_arb_pkg::*;

    localparam int unsigned N    = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned IDXW = 1;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;

    logic [N*AW-1:0] s_axil_awaddr;
    logic [N*3-1:0]  s_axil_awprot;
    logic [N-1:0]    s_axil_awvalid;
    logic [N-1:0]    s_axil_awready;
    logic [N*DW-1:0] s_axil_wdata;
    logic [N*SW-1:0] s_axil_wstrb;
    logic [N-1:0]    s_axil_wvalid;
    logic [N-1:0]    s_axil_wready;
    logic [N*2-1:0]  s_axil_bresp;
    logic [N-1:0]    s_axil_bvalid;
    logic [N-1:0]    s_axil_bready;
    logic [N*AW-1:0] s_axil_araddr;
    logic [N*3-1:0]  s_axil_arprot;
    logic [N-1:0]    s_axil_arvalid;
    logic [N-1:0]    s_axil_arready;
    logic [N*DW-1:0] s_axil_rdata;
    logic [N*2-1:0]  s_axil_rresp;
    logic [N-1:0]    s_axil_rvalid;
    logic [N-1:0]    s_axil_rready;

    logic [AW-1:0]   m_axil_awaddr;
    logic [2:0]      m_axil_awprot;
    logic            m_axil_awvalid;
    logic            m_axil_awready;
    logic [DW-1:0]   m_axil_wdata;
    logic [SW-1:0]   m_axil_wstrb;
    logic            m_axil_wvalid;
    logic            m_axil_wready;
    logic [1:0]      m_axil_bresp;
    logic            m_axil_bvalid;
    logic            m_axil_bready;
    logic [AW-1:0]   m_axil_araddr;
    logic [2:0]      m_axil_arprot;
    logic            m_axil_arvalid;
    logic            m_axil_arready;
    logic [DW-1:0]   m_axil_rdata;
    logic [1:0]      m_axil_rresp;
    logic            m_axil_rvalid;
    logic            m_axil_rready;
    logic [IDXW-1:0] wr_grant;
    logic [IDXW-1:0] rd_grant;

    axil_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_wg[$];
    exp_t exp_wd[$];
    exp_t exp_b[$];
    exp_t exp_rg[$];
    exp_t exp_r[$];

    int   aw_dly = 0;
    int   w_dly  = 0;
    logic [1:0] sl_bresp = OKAY;

    int   cyc = 0;
    int   aw_rise = 0, w_rise = 0;
    logic aw_prev = 1'b0, w_prev = 1'b0, b_prev = 1'b0;
    int   aw_hs_cyc = 0, w_hs_cyc = 0, b_rise_cyc = 0;
    int   last_r_cyc = -1;
    bit   gap_chk = 1'b0;
    int   act0 = 0, bv1_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Downstream slave: programmable AW/W ready delays, rdata echoes the address.
    logic       aw_got, w_got;
    int         aw_cnt, w_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axil_awready <= 1'b0; m_axil_wready <= 1'b0; m_axil_arready <= 1'b0;
            m_axil_bvalid <= 1'b0; m_axil_bresp <= 2'b00;
            m_axil_rvalid <= 1'b0; m_axil_rdata <= '0; m_axil_rresp <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
        end else begin
            m_axil_arready <= 1'b1;
            if (m_axil_awvalid && m_axil_awready) begin
                m_axil_awready <= 1'b0; aw_got <= 1'b1; aw_cnt <= 0;
            end else if (m_axil_awvalid && !aw_got) begin
                if (aw_cnt >= aw_dly) m_axil_awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (m_axil_wvalid && m_axil_wready) begin
                m_axil_wready <= 1'b0; w_got <= 1'b1; w_cnt <= 0;
            end else if (m_axil_wvalid && !w_got) begin
                if (w_cnt >= w_dly) m_axil_wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
            if (aw_got && w_got && !m_axil_bvalid) begin
                m_axil_bvalid <= 1'b1; m_axil_bresp <= sl_bresp;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (m_axil_arvalid && m_axil_arready) begin
                m_axil_rvalid <= 1'b1; m_axil_rdata <= m_axil_araddr; m_axil_rresp <= OKAY;
            end else if (m_axil_rvalid && m_axil_rready) begin
                m_axil_rvalid <= 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake it sees.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            cyc++;
            if (m_axil_awvalid && !aw_prev) aw_rise++;
            if (m_axil_wvalid && !w_prev) w_rise++;
            if (m_axil_bvalid && !b_prev) b_rise_cyc = cyc;
            aw_prev = m_axil_awvalid; w_prev = m_axil_wvalid; b_prev = m_axil_bvalid;
            if (s_axil_awready[0] || s_axil_wready[0] || s_axil_bvalid[0]) act0++;
            if (s_axil_bvalid[1]) bv1_cnt++;
            if (m_axil_awvalid && m_axil_awready) begin
                aw_hs_cyc = cyc;
                if (exp_wg.size() == 0) chk("aw_unexpected", 32'(exp_wg.size()), 1);
                else begin
                    e = exp_wg.pop_front();
                    chk("wr_grant", 32'(wr_grant), 32'(e.idx));
                    chk("m_awaddr", m_axil_awaddr, e.val);
                end
            end
            if (m_axil_wvalid && m_axil_wready) begin
                w_hs_cyc = cyc;
                if (exp_wd.size() == 0) chk("w_unexpected", 32'(exp_wd.size()), 1);
                else begin
                    e = exp_wd.pop_front();
                    chk("w_grant", 32'(wr_grant), 32'(e.idx));
                    chk("m_wdata", m_axil_wdata, e.val);
                end
            end
            if (m_axil_arvalid && m_axil_arready) begin
                if (gap_chk && last_r_cyc >= 0) chk("rd_gap", 32'(cyc - last_r_cyc), 2);
                if (exp_rg.size() == 0) chk("ar_unexpected", 32'(exp_rg.size()), 1);
                else begin
                    e = exp_rg.pop_front();
                    chk("rd_grant", 32'(rd_grant), 32'(e.idx));
                    chk("m_araddr", m_axil_araddr, e.val);
                end
            end
            if (m_axil_rvalid && m_axil_rready) last_r_cyc = cyc;
            for (int i = 0; i < int'(N); i++) begin
                if (s_axil_bvalid[i] && s_axil_bready[i]) begin
                    if (exp_b.size() == 0) chk("b_unexpected", 32'(exp_b.size()), 1);
                    else begin
                        e = exp_b.pop_front();
                        chk("b_idx", 32'(i), 32'(e.idx));
                        chk("bresp", 32'(s_axil_bresp[i*2 +: 2]), e.val);
                    end
                end
                if (s_axil_rvalid[i] && s_axil_rready[i]) begin
                    if (exp_r.size() == 0) chk("r_unexpected", 32'(exp_r.size()), 1);
                    else begin
                        e = exp_r.pop_front();
                        chk("r_idx", 32'(i), 32'(e.idx));
                        chk("rdata", s_axil_rdata[i*DW +: DW], e.val);
                        chk("rresp", 32'(s_axil_rresp[i*2 +: 2]), 32'(OKAY));
                    end
                end
            end
        end
    end

    task automatic do_write(input int idx, input logic [31:0] addr, input logic [31:0] data,
                            input int hold);
        bit aw_ok = 0, w_ok = 0, b_ok = 0, aw_f, w_f, b_f;
        int bud = 0, bv_seen = 0;
        s_axil_awaddr[idx*AW +: AW] = addr;
        s_axil_awprot[idx*3 +: 3]   = 3'b000;
        s_axil_wdata[idx*DW +: DW]  = data;
        s_axil_wstrb[idx*SW +: SW]  = 4'hF;
        s_axil_awvalid[idx] = 1'b1;
        s_axil_wvalid[idx]  = 1'b1;
        s_axil_bready[idx]  = (hold == 0);
        while (!(aw_ok && w_ok) && bud < 200) begin
            @(negedge clk); bud++;
            aw_f = s_axil_awvalid[idx] && s_axil_awready[idx];
            w_f  = s_axil_wvalid[idx] && s_axil_wready[idx];
            @(posedge clk); #1;
            if (aw_f) begin s_axil_awvalid[idx] = 1'b0; aw_ok = 1; end
            if (w_f)  begin s_axil_wvalid[idx]  = 1'b0; w_ok  = 1; end
        end
        chk("wr_addr_done", 32'(aw_ok && w_ok), 1);
        bud = 0;
        while (!b_ok && bud < 200) begin
            @(negedge clk); bud++;
            b_f = s_axil_bvalid[idx] && s_axil_bready[idx];
            if (s_axil_bvalid[idx]) bv_seen++;
            @(posedge clk); #1;
            if (b_f) begin s_axil_bready[idx] = 1'b0; b_ok = 1; end
            else if (bv_seen >= hold) s_axil_bready[idx] = 1'b1;
        end
        chk("wr_resp_done", 32'(b_ok), 1);
    endtask

    task automatic do_read(input int idx, input logic [31:0] addr);
        bit ok = 0, f;
        int bud = 0;
        s_axil_araddr[idx*AW +: AW] = addr;
        s_axil_arprot[idx*3 +: 3]   = 3'b000;
        s_axil_arvalid[idx] = 1'b1;
        s_axil_rready[idx]  = 1'b1;
        while (!ok && bud < 200) begin
            @(negedge clk); bud++;
            f = s_axil_arvalid[idx] && s_axil_arready[idx];
            @(posedge clk); #1;
            if (f) begin s_axil_arvalid[idx] = 1'b0; ok = 1; end
        end
        chk("rd_addr_done", 32'(ok), 1);
        ok = 0; bud = 0;
        while (!ok && bud < 200) begin
            @(negedge clk); bud++;
            f = s_axil_rvalid[idx] && s_axil_rready[idx];
            @(posedge clk); #1;
            if (f) begin s_axil_rready[idx] = 1'b0; ok = 1; end
        end
        chk("rd_data_done", 32'(ok), 1);
    endtask

    task automatic push_wr(input int idx, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
        exp_wg.push_back('{idx: 8'(idx), val: addr});
        exp_wd.push_back('{idx: 8'(idx), val: data});
        exp_b.push_back('{idx: 8'(idx), val: 32'(resp)});
    endtask

    task automatic push_rd(input int idx, input logic [31:0] addr);
        exp_rg.push_back('{idx: 8'(idx), val: addr});
        exp_r.push_back('{idx: 8'(idx), val: addr});
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m_awvalid"}, 32'(m_axil_awvalid), 0);
        chk({tag, "_m_wvalid"},  32'(m_axil_wvalid), 0);
        chk({tag, "_m_arvalid"}, 32'(m_axil_arvalid), 0);
        chk({tag, "_m_bready"},  32'(m_axil_bready), 0);
        chk({tag, "_s_awready"}, 32'(s_axil_awready), 0);
        chk({tag, "_s_wready"},  32'(s_axil_wready), 0);
        chk({tag, "_s_bvalid"},  32'(s_axil_bvalid), 0);
        chk({tag, "_wr_grant"},  32'(wr_grant), 0);
        chk({tag, "_rd_grant"},  32'(rd_grant), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, b1, bud;
        bit seen;
        reset = 1'b1;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = '0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = '0; s_axil_bready = '0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = '0; s_axil_rready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Single write from requester 1; awvalid reaches the master one cycle later.
        @(posedge clk); #1;
        push_wr(1, 32'h40, 32'hDEADBEEF, OKAY);
        a0 = act0;
        fork
            do_write(1, 32'h40, 32'hDEADBEEF, 0);
            begin
                @(negedge clk); chk("t1_awvalid_early", 32'(m_axil_awvalid), 0);
                @(negedge clk); chk("t1_awvalid_rise", 32'(m_axil_awvalid), 1);
                chk("t1_wr_grant", 32'(wr_grant), 1);
            end
        join
        chk("t1_req0_quiet", 32'(act0 - a0), 0);

        // Two continuous readers alternate with one idle cycle between transactions.
        push_rd(0, 32'h1000); push_rd(1, 32'h2000); push_rd(0, 32'h1004); push_rd(1, 32'h2004);
        gap_chk = 1'b1; last_r_cyc = -1;
        fork
            begin do_read(0, 32'h1000); do_read(0, 32'h1004); end
            begin do_read(1, 32'h2000); do_read(1, 32'h2004); end
        join
        gap_chk = 1'b0;

        // W accepted 3 cycles before AW, then AW 3 cycles before W.
        aw_dly = 3; w_dly = 0; aw_rise = 0; w_rise = 0;
        push_wr(0, 32'h100, 32'h11111111, OKAY);
        do_write(0, 32'h100, 32'h11111111, 0);
        chk("t3a_aw_pulses", 32'(aw_rise), 1);
        chk("t3a_w_pulses", 32'(w_rise), 1);
        chk("t3a_w_lead", 32'(aw_hs_cyc - w_hs_cyc), 3);
        chk("t3a_b_after", 32'(b_rise_cyc > aw_hs_cyc), 1);
        aw_dly = 0; w_dly = 3; aw_rise = 0; w_rise = 0;
        push_wr(1, 32'h104, 32'h22222222, OKAY);
        do_write(1, 32'h104, 32'h22222222, 0);
        chk("t3b_aw_pulses", 32'(aw_rise), 1);
        chk("t3b_w_pulses", 32'(w_rise), 1);
        chk("t3b_aw_lead", 32'(w_hs_cyc - aw_hs_cyc), 3);
        chk("t3b_b_after", 32'(b_rise_cyc > w_hs_cyc), 1);
        w_dly = 0;

        // Concurrent write (req 0, SLVERR) and read (req 1).
        sl_bresp = SLVERR;
        b1 = bv1_cnt;
        push_wr(0, 32'h80, 32'hCAFEF00D, SLVERR);
        push_rd(1, 32'h3000);
        fork
            do_write(0, 32'h80, 32'hCAFEF00D, 0);
            do_read(1, 32'h3000);
            begin
                repeat (2) @(negedge clk);
                chk("t4_wr_grant", 32'(wr_grant), 0);
                chk("t4_rd_grant", 32'(rd_grant), 1);
                chk("t4_both_valid", 32'(m_axil_awvalid && m_axil_arvalid), 1);
            end
        join
        chk("t4_no_b_req1", 32'(bv1_cnt - b1), 0);
        sl_bresp = OKAY;

        // Requester 0 stalls bready; requester 1's pending write must wait.
        push_wr(0, 32'h500, 32'h55555555, OKAY);
        push_wr(1, 32'h600, 32'h66666666, OKAY);
        fork
            do_write(0, 32'h500, 32'h55555555, 5);
            begin repeat (3) @(posedge clk); #1; do_write(1, 32'h600, 32'h66666666, 0); end
            begin
                seen = 0; bud = 0;
                while (!seen && bud < 100) begin @(negedge clk); bud++; seen = s_axil_bvalid[0]; end
                chk("t5_bvalid_seen", 32'(seen), 1);
                for (int k = 0; k < 4; k++) begin
                    chk("t5_m_bready_low", 32'(m_axil_bready), 0);
                    chk("t5_no_new_grant", 32'(m_axil_awvalid || wr_grant != 1'b0), 0);
                    @(negedge clk);
                end
            end
        join

        // Reset after the AW handshake, before W completes.
        w_dly = 8;
        exp_wg.push_back('{idx: 8'd1, val: 32'h700});
        @(posedge clk); #1;
        s_axil_awaddr[AW +: AW] = 32'h700; s_axil_wdata[DW +: DW] = 32'h77777777;
        s_axil_wstrb[SW +: SW] = 4'hF;
        s_axil_awvalid[1] = 1'b1; s_axil_wvalid[1] = 1'b1; s_axil_bready[1] = 1'b1;
        seen = 0; bud = 0;
        while (!seen && bud < 100) begin
            @(negedge clk); bud++;
            seen = s_axil_awvalid[1] && s_axil_awready[1];
        end
        chk("t6_aw_seen", 32'(seen), 1);
        @(posedge clk); #1; s_axil_awvalid[1] = 1'b0;
        @(negedge clk);
        chk("t6_w_pending", 32'(m_axil_wvalid), 1);
        #2 reset = 1'b1;
        #1 chk_idle_outputs("t6_async");
        s_axil_wvalid[1] = 1'b0; s_axil_bready[1] = 1'b0;
        w_dly = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push_wr(0, 32'h800, 32'h88888888, OKAY);
        push_wr(1, 32'h804, 32'h99999999, OKAY);
        fork
            do_write(0, 32'h800, 32'h88888888, 0);
            do_write(1, 32'h804, 32'h99999999, 0);
        join

        repeat (5) @(posedge clk);
        chk("end_exp_wg", 32'(exp_wg.size()), 0);
        chk("end_exp_wd", 32'(exp_wd.size()), 0);
        chk("end_exp_b", 32'(exp_b.size()), 0);
        chk("end_exp_rg", 32'(exp_rg.size()), 0);
        chk("end_exp_r", 32'(exp_r.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
